instr_memory_ctrl: RTL and testbench

//  Byte-addressed instruction memory with a streaming loader and a handshaked fetch port.

---
 rtl/instr_memory_ctrl_pkg.sv | 14 +
 rtl/instr_memory_ctrl_if.sv | 42 ++++
 rtl/instr_memory_ctrl_pmem_bank.sv | 45 ++++
 rtl/instr_memory_ctrl.sv | 113 +++++++++++
 tb/tb_instr_memory_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_memory_ctrl_pkg.sv
// Shared definitions for the instruction memory controller.
//   state_t      : controller FSM states (idle after reset, loading, fetch-serving)
//   INSTR_FAULT  : instruction word presented alongside a fetch fault
package instr_memory_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2
    } state_t;

    localparam logic [31:0] INSTR_FAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_memory_ctrl_if.sv
// Load and fetch bus of the instruction memory controller.
//   load side  : load_start, ld_valid/ld_data/ld_last -> ld_ready, ld_overflow
//   fetch side : fetch_valid/fetch_addr -> fetch_ready, flush
//   instr side : instr_valid/instr/instr_pc/fetch_fault <- instr_ready
//   status     : busy
// master = program loader / fetch stage, slave = the controller.
interface instr_memory_ctrl_if #(
    parameter int unsigned PC_WIDTH  = 12,
    parameter int unsigned OPD_WIDTH = 32
);
    logic                 load_start;
    logic                 ld_valid;
    logic [7:0]           ld_data;
    logic                 ld_last;
    logic                 ld_ready;
    logic                 ld_overflow;
    logic                 fetch_valid;
    logic [PC_WIDTH-1:0]  fetch_addr;
    logic                 fetch_ready;
    logic                 flush;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [31:0]          instr;
    logic [OPD_WIDTH-1:0] instr_pc;
    logic                 fetch_fault;
    logic                 busy;

    modport master (
        output load_start, ld_valid, ld_data, ld_last, fetch_valid, fetch_addr, flush,
               instr_ready,
        input  ld_ready, ld_overflow, fetch_ready, instr_valid, instr, instr_pc, fetch_fault,
               busy
    );

    modport slave (
        input  load_start, ld_valid, ld_data, ld_last, fetch_valid, fetch_addr, flush,
               instr_ready,
        output ld_ready, ld_overflow, fetch_ready, instr_valid, instr, instr_pc, fetch_fault,
               busy
    );

endinterface

// File: rtl/instr_memory_ctrl_pmem_bank.sv
// Byte-wide program memory with one write port and a registered 32-bit little-endian read.
//   clk, rst  : clock; async active-high reset clears only the read register
//   we/waddr/wdata : byte write
//   rd_en/rd_addr  : read of {mem[a+3],mem[a+2],mem[a+1],mem[a]}; rd_data holds when rd_en=0
// The byte array itself is never reset so a program survives rst.
module instr_memory_ctrl_pmem_bank #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [7:0]    mem [DEPTH];
    logic [31:0]   rd_data_q;
    logic [AW-1:0] a1, a2, a3;

    // Callers only read aligned, in-range words, so these never actually wrap.
    assign a1 = rd_addr + AW'(1);
    assign a2 = rd_addr + AW'(2);
    assign a3 = rd_addr + AW'(3);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= {mem[a3], mem[a2], mem[a1], mem[rd_addr]};
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_memory_ctrl.sv
// Instruction memory controller: streams a program in byte by byte, then serves
// handshaked 32-bit fetches with a one-entry hold register, flush and fault reporting.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of instr_memory_ctrl_if (load port, fetch port, instr port, busy)
module instr_memory_ctrl
    import instr_memory_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 12,
    parameter int unsigned OPD_WIDTH = 32,
    parameter int unsigned LOAD_BASE = 0
) (
    input logic              clk,
    input logic              rst,
    instr_memory_ctrl_if.slave bus
);
    localparam logic [PC_WIDTH-1:0] BASE_ADDR = PC_WIDTH'(LOAD_BASE);
    localparam logic [PC_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [PC_WIDTH-1:0] MAX_FETCH = LAST_ADDR - PC_WIDTH'(3);

    state_t              state_q;
    logic [PC_WIDTH-1:0] ptr_q;
    logic                overflow_q;
    logic                valid_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                fault_q;

    logic                ld_accept;
    logic                fetch_ready;
    logic                fetch_accept;
    logic                fault_now;
    logic [31:0]         rd_data;

    assign ld_accept    = (state_q == StLoad) && bus.ld_valid;
    // A load_start in RUN wins over a same-cycle request so nothing is silently dropped.
    assign fetch_ready  = (state_q == StRun) && !bus.load_start &&
                          (!valid_q || bus.instr_ready || bus.flush);
    assign fetch_accept = bus.fetch_valid && fetch_ready;
    assign fault_now    = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr > MAX_FETCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= BASE_ADDR;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            fault_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.load_start) begin
                        state_q    <= StLoad;
                        ptr_q      <= BASE_ADDR;
                        overflow_q <= 1'b0;
                    end
                end
                StLoad: begin
                    if (bus.load_start) begin
                        ptr_q <= BASE_ADDR;
                    end else if (ld_accept) begin
                        ptr_q <= ptr_q + PC_WIDTH'(1);
                        if (bus.ld_last) begin
                            state_q <= StRun;
                        end else if (ptr_q == LAST_ADDR) begin
                            state_q    <= StRun;
                            overflow_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (bus.load_start) begin
                        state_q    <= StLoad;
                        ptr_q      <= BASE_ADDR;
                        overflow_q <= 1'b0;
                        valid_q    <= 1'b0;
                    end else if (fetch_accept) begin
                        valid_q <= 1'b1;
                        pc_q    <= bus.fetch_addr;
                        fault_q <= fault_now;
                    end else if (bus.instr_ready || bus.flush) begin
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Faulting fetches leave the read register untouched; the output mux substitutes the
    // fault word, which also keeps the bank from ever reading past the top of memory.
    instr_memory_ctrl_pmem_bank #(
        .AW (PC_WIDTH)
    ) u_pmem_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (ld_accept),
        .waddr   (ptr_q),
        .wdata   (bus.ld_data),
        .rd_en   (fetch_accept && !fault_now),
        .rd_addr (bus.fetch_addr),
        .rd_data (rd_data)
    );

    assign bus.ld_ready    = (state_q == StLoad);
    assign bus.ld_overflow = overflow_q;
    assign bus.fetch_ready = fetch_ready;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = fault_q ? INSTR_FAULT : rd_data;
    assign bus.instr_pc    = OPD_WIDTH'(pc_q);
    assign bus.fetch_fault = fault_q;
    assign bus.busy        = (state_q != StRun);

endmodule

// File: tb/tb_instr_memory_ctrl.sv
module tb_instr_memory_ctrl;
    localparam int MEM = 4096;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    // Reference: byte image of memory plus the expected contents of the instr port.
    logic [7:0]  model [MEM];
    logic        ev;
    logic [31:0] einstr;
    logic [31:0] epc;
    logic        efault;
    logic [7:0]  src_q[$];

    instr_memory_ctrl_if #(.PC_WIDTH(12), .OPD_WIDTH(32)) bus ();

    instr_memory_ctrl #(
        .PC_WIDTH  (12),
        .OPD_WIDTH (32),
        .LOAD_BASE (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_fault(input int a);
        return (a % 4 != 0) || (a > MEM - 4);
    endfunction

    function automatic logic [31:0] ref_instr(input int a);
        if (ref_fault(a)) return 32'h0;
        return {model[a+3], model[a+2], model[a+1], model[a]};
    endfunction

    task automatic check_out(input string tag);
        check({tag, "_valid"}, bus.instr_valid, ev);
        check({tag, "_instr"}, bus.instr, einstr);
        check({tag, "_pc"}, bus.instr_pc, epc);
        check({tag, "_fault"}, bus.fetch_fault, efault);
    endtask

    // Load session from address 0; bytes come from src_q first, then random.
    task automatic load(input int n, input bit use_last);
        logic [7:0] b;
        bus.load_start = 1'b1;
        tick;
        bus.load_start = 1'b0;
        ev = 1'b0;
        check("load_ld_ready", bus.ld_ready, 1);
        check("load_busy", bus.busy, 1);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) tick;
            b = (src_q.size() != 0) ? src_q.pop_front() : 8'($urandom);
            bus.ld_valid = 1'b1;
            bus.ld_data  = b;
            bus.ld_last  = use_last && (i == n - 1);
            tick;
            model[i] = b;
            bus.ld_valid = 1'b0;
            bus.ld_last  = 1'b0;
        end
    endtask

    // One accepted fetch; consumer then stalls so the result is held.
    task automatic fetch(input int a, input string tag);
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 12'(a);
        bus.instr_ready = 1'b1;
        bus.flush       = 1'b0;
        #1;
        check({tag, "_fetch_ready"}, bus.fetch_ready, 1);
        tick;
        bus.fetch_valid = 1'b0;
        bus.instr_ready = 1'b0;
        ev = 1'b1; epc = 32'(a); efault = ref_fault(a); einstr = ref_instr(a);
        #1;
        check_out(tag);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        clk = 1'b0; rst = 1'b1;
        bus.load_start = 0; bus.ld_valid = 0; bus.ld_data = 0; bus.ld_last = 0;
        bus.fetch_valid = 0; bus.fetch_addr = 0; bus.flush = 0; bus.instr_ready = 0;
        ev = 0; einstr = 0; epc = 0; efault = 0;

        // Reset state
        repeat (2) tick;
        rst = 1'b0;
        #1;
        check("rst_busy", bus.busy, 1);
        check("rst_ld_ready", bus.ld_ready, 0);
        check("rst_fetch_ready", bus.fetch_ready, 0);
        check("rst_overflow", bus.ld_overflow, 0);
        check_out("rst");

        // 1: small program, two fetches
        src_q = '{8'h13, 8'h01, 8'h30, 8'h00, 8'h13, 8'h02, 8'h40, 8'h00};
        load(8, 1'b1);
        #1;
        check("s1_busy", bus.busy, 0);
        check("s1_overflow", bus.ld_overflow, 0);
        check("s1_ld_ready", bus.ld_ready, 0);
        fetch(0, "s1_f0");
        check("s1_instr0_const", bus.instr, 32'h00300113);
        fetch(4, "s1_f4");
        check("s1_instr4_const", bus.instr, 32'h00400213);

        // 2: consumer stalls for 5 cycles with a pending request
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 12'h000;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("s2_stall_ready", bus.fetch_ready, 0);
            tick;
            check_out("s2_hold");
        end
        bus.instr_ready = 1'b1;
        #1;
        check("s2_release_ready", bus.fetch_ready, 1);
        tick;
        bus.fetch_valid = 1'b0;
        bus.instr_ready = 1'b0;
        epc = 0; efault = 0; einstr = ref_instr(0);
        #1;
        check_out("s2_after");

        // 5: flush with a request in the same cycle, then flush alone
        bus.flush = 1'b1; bus.fetch_valid = 1'b1; bus.fetch_addr = 12'h004;
        #1;
        check("s5_ready", bus.fetch_ready, 1);
        tick;
        bus.fetch_valid = 1'b0;
        epc = 4; efault = 0; einstr = ref_instr(4);
        #1;
        check_out("s5_new");
        tick;
        bus.flush = 1'b0;
        ev = 1'b0;
        #1;
        check("s5_flushed_valid", bus.instr_valid, 0);

        // 4: fill the whole memory without ld_last
        load(MEM, 1'b0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = ~model[0];
        #1;
        check("s4_overflow", bus.ld_overflow, 1);
        check("s4_busy", bus.busy, 0);
        check("s4_refused", bus.ld_ready, 0);
        tick;
        bus.ld_valid = 1'b0;
        fetch(0, "s4_f0");

        // 3: alignment / range faults
        fetch(12'h002, "s3_f002");
        fetch(12'hFFE, "s3_fFFE");
        fetch(12'hFFD, "s3_fFFD");
        fetch(12'hFFC, "s3_fFFC");

        // Random traffic against the model
        for (int c = 0; c < 300; c++) begin
            logic fv, ir, fl, rdy;
            int   a;
            fv = 1'($urandom); ir = 1'($urandom); fl = ($urandom_range(0, 5) == 0);
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MEM - 1))
                                             : int'($urandom_range(0, MEM / 4 - 1)) * 4;
            bus.fetch_valid = fv; bus.fetch_addr = 12'(a);
            bus.instr_ready = ir; bus.flush = fl;
            rdy = !ev || ir || fl;
            #1;
            check("rnd_fetch_ready", bus.fetch_ready, rdy);
            tick;
            if (fv && rdy) begin
                ev = 1'b1; epc = 32'(a); efault = ref_fault(a); einstr = ref_instr(a);
            end else if (ir || fl) begin
                ev = 1'b0;
            end
            #1;
            check("rnd_valid", bus.instr_valid, ev);
            if (ev) begin
                check("rnd_instr", bus.instr, einstr);
                check("rnd_pc", bus.instr_pc, epc);
                check("rnd_fault", bus.fetch_fault, efault);
            end
        end
        bus.fetch_valid = 0; bus.instr_ready = 0; bus.flush = 0;

        // 6: reset after 3 bytes of a load, memory contents survive
        bus.load_start = 1'b1;
        tick;
        bus.load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            bus.ld_valid = 1'b1; bus.ld_data = b;
            tick;
            model[i] = b;
        end
        bus.ld_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        ev = 0; einstr = 0; epc = 0; efault = 0;
        check("s6_busy", bus.busy, 1);
        check("s6_ld_ready", bus.ld_ready, 0);
        check("s6_fetch_ready", bus.fetch_ready, 0);
        check("s6_overflow", bus.ld_overflow, 0);
        check_out("s6_rst");
        tick;
        rst = 1'b0;
        src_q.delete();
        load(1, 1'b1);
        fetch(0, "s6_f0");
        fetch(4, "s6_f4");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
